// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares one data-bus port between N_MASTERS requesters, one whole transaction at a time.
// Define DBUS_ARB_RR_EN for round-robin arbitration; by default master 0 has fixed highest priority.
package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    localparam int IDX_W = $clog2(N_MASTERS)
) (
    input  logic             clk,
    input  logic             rst,
    input  dbus_req_t        mreq  [N_MASTERS],
    output dbus_resp_t       mresp [N_MASTERS],
    output dbus_req_t        dreq,
    input  dbus_resp_t       dresp,
    output logic [IDX_W-1:0] owner,
    output logic             busy
);
    // Handshake: a master's request is taken when it wins arbitration in IDLE; the master keeps
    // valid and all fields stable until it sees data_ok, which ends the grant.
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] winner;
    logic             any_valid;

`ifdef DBUS_ARB_RR_EN
    logic [IDX_W-1:0] cand;

    // Search starts just after the last completed winner and wraps.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = IDX_W'((int'(last_q) + k) % N_MASTERS);
            if (!any_valid && mreq[cand].valid) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
    end
`else
    logic last_unused;
    assign last_unused = ^last_q;

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (mreq[k].valid) begin
                winner    = IDX_W'(k);
                any_valid = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(N_MASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state   <= BUSY;
                        owner_q <= winner;
                    end
                end
                BUSY: begin
                    // The grant is held even if the owner drops valid early.
                    if (dresp.data_ok) begin
                        state  <= IDLE;
                        last_q <= owner_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dreq = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            mresp[j] = '0;
            if (rst && state == BUSY && owner_q == IDX_W'(j)) begin
                dreq     = mreq[j];
                mresp[j] = dresp;
            end
        end
    end

    assign busy  = (state == BUSY);
    assign owner = owner_q;
endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed steps plus a randomized phase against a cycle model.
module tb_dbus_arbiter;
    import dbus_pkg::*;
    localparam int N = 2;
`ifdef DBUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    dbus_req_t  mreq  [N];
    dbus_resp_t mresp [N];
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic [0:0] owner;
    logic       busy;

    dbus_arbiter #(.N_MASTERS(N)) dut (
        .clk(clk), .rst(rst), .mreq(mreq), .mresp(mresp),
        .dreq(dreq), .dresp(dresp), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit m_busy;
    int m_owner;
    int m_last;
    bit prev_busy;
    bit done [N];
    int remaining [N];
    int lat_cnt;
    bit auto_en;
    bit gap_en;
    int grant_q[$];
    logic [0:0] exp_q[$];

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] rq(input dbus_req_t r);
        return {20'd0, r};
    endfunction

    function automatic logic [159:0] rs(input dbus_resp_t r);
        return {94'd0, r};
    endfunction

    // Arbitration rule: scan upward from a start index, wrapping; RR starts after the last winner.
    function automatic int pick(input int last);
        int start;
        int i;
        start = RR ? (last + 1) % N : 0;
        for (int off = 0; off < N; off++) begin
            i = (start + off) % N;
            if (mreq[i].valid) return i;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++)
            if (remaining[i] > 0 || mreq[i].valid) return 1'b1;
        return 1'b0;
    endfunction

    function automatic dbus_req_t rand_req();
        dbus_req_t r;
        r.valid  = 1'b1;
        r.addr   = {$urandom, $urandom};
        r.size   = 3'($urandom_range(0, 3));
        r.strobe = 8'($urandom);
        r.data   = {$urandom, $urandom};
        return r;
    endfunction

    task automatic set_req(input int i, input bit v, input logic [63:0] a, input logic [2:0] s,
                           input logic [7:0] st, input logic [63:0] d);
        mreq[i].valid  = v;
        mreq[i].addr   = a;
        mreq[i].size   = s;
        mreq[i].strobe = st;
        mreq[i].data   = d;
    endtask

    task automatic set_resp(input bit aok, input bit dok, input logic [63:0] d);
        dresp.addr_ok = aok;
        dresp.data_ok = dok;
        dresp.data    = d;
    endtask

    // Masters re-issue after data_ok while they have work; slave answers after a random latency.
    task automatic drive_auto();
        for (int i = 0; i < N; i++) begin
            if (done[i] || !mreq[i].valid) begin
                if (remaining[i] > 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
                    remaining[i]--;
                    mreq[i] = rand_req();
                end else begin
                    mreq[i] = '0;
                end
            end
        end
        if (m_busy) begin
            if (lat_cnt == 0) begin
                dresp = {1'($urandom), 1'b1, $urandom, $urandom};
            end else begin
                dresp = {1'($urandom), 1'b0, $urandom, $urandom};
                lat_cnt--;
            end
        end else begin
            dresp = {1'($urandom), 1'($urandom), $urandom, $urandom};
        end
    endtask

    // One clock: check outputs against the model at negedge, advance the model, step past posedge.
    task automatic cyc();
        int w;
        @(negedge clk);
        chk("busy", {159'd0, busy}, {159'd0, m_busy});
        chk("owner", {159'd0, owner}, {159'd0, m_owner[0]});
        chk("dreq", rq(dreq), m_busy ? rq(mreq[m_owner]) : 160'd0);
        for (int j = 0; j < N; j++)
            chk($sformatf("mresp%0d", j), rs(mresp[j]), (m_busy && j == m_owner) ? rs(dresp) : 160'd0);
        if (busy && !prev_busy) grant_q.push_back(int'(owner));
        prev_busy = busy;
        for (int j = 0; j < N; j++) done[j] = m_busy && (j == m_owner) && dresp.data_ok;
        if (!m_busy) begin
            w = pick(m_last);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                lat_cnt = $urandom_range(0, 3);
            end
        end else if (dresp.data_ok) begin
            m_busy = 1'b0;
            m_last = m_owner;
        end
        @(posedge clk);
        #1;
        if (auto_en) drive_auto();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            mreq[i]   = '0;
            done[i]   = 1'b0;
        end
        dresp     = '0;
        m_busy    = 1'b0;
        m_owner   = 0;
        m_last    = N - 1;
        prev_busy = 1'b0;
        #1;
        chk("rst_busy", {159'd0, busy}, 160'd0);
        chk("rst_owner", {159'd0, owner}, 160'd0);
        chk("rst_dreq", rq(dreq), 160'd0);
        for (int j = 0; j < N; j++) chk($sformatf("rst_mresp%0d", j), rs(mresp[j]), 160'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((pending() || m_busy) && c < budget) begin
            cyc();
            c++;
        end
        chk("drain_budget", {159'd0, pending() || m_busy}, 160'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int g;
        auto_en = 1'b0;
        gap_en  = 1'b0;
        lat_cnt = 0;
        for (int i = 0; i < N; i++) remaining[i] = 0;
        #1;
        apply_reset();

        // Single master read, data_ok after three busy cycles.
        set_req(0, 1'b1, 64'h8000_0010, 3'b011, 8'h00, 64'h0);
        cyc();
        chk("t1_dreq_valid", {159'd0, dreq.valid}, {159'd0, 1'b1});
        chk("t1_dreq_addr", {96'd0, dreq.addr}, {96'd0, 64'h8000_0010});
        cyc();
        cyc();
        set_resp(1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
        #1;
        chk("t1_mresp0_data", {96'd0, mresp[0].data}, {96'd0, 64'hDEAD_BEEF_0000_0001});
        chk("t1_mresp1_data_ok", {159'd0, mresp[1].data_ok}, 160'd0);
        cyc();
        set_req(0, 1'b0, 64'h0, 3'b000, 8'h00, 64'h0);
        set_resp(1'b0, 1'b0, 64'h0);
        #1;
        chk("t1_busy_fall", {159'd0, busy}, 160'd0);
        cyc();

        // Master 1 arrives mid-transaction, then its write passes through untouched.
        set_req(0, 1'b1, 64'h8000_0100, 3'b011, 8'h0F, 64'h1111_2222_3333_4444);
        cyc();
        set_req(1, 1'b1, 64'h8000_0008, 3'b011, 8'hFF, 64'h0123_4567_89AB_CDEF);
        cyc();
        chk("t4_hold_addr", {96'd0, dreq.addr}, {96'd0, 64'h8000_0100});
        set_resp(1'b1, 1'b0, 64'h0);
        cyc();
        chk("t4_hold_data", {96'd0, dreq.data}, {96'd0, 64'h1111_2222_3333_4444});
        set_resp(1'b0, 1'b1, 64'h5);
        cyc();
        set_req(0, 1'b0, 64'h0, 3'b000, 8'h00, 64'h0);
        set_resp(1'b0, 1'b0, 64'h0);
        #1;
        chk("t4_gap_busy", {159'd0, busy}, 160'd0);
        chk("t4_gap_dreq_valid", {159'd0, dreq.valid}, 160'd0);
        cyc();
        chk("t6_owner", {159'd0, owner}, {159'd0, 1'b1});
        chk("t6_addr", {96'd0, dreq.addr}, {96'd0, 64'h8000_0008});
        chk("t6_strobe", {152'd0, dreq.strobe}, {152'd0, 8'hFF});
        chk("t6_data", {96'd0, dreq.data}, {96'd0, 64'h0123_4567_89AB_CDEF});
        set_resp(1'b1, 1'b1, 64'hAA);
        #1;
        chk("t6_m1_data_ok", {159'd0, mresp[1].data_ok}, {159'd0, 1'b1});
        chk("t6_m0_data_ok", {159'd0, mresp[0].data_ok}, 160'd0);
        cyc();
        set_req(1, 1'b0, 64'h0, 3'b000, 8'h00, 64'h0);
        set_resp(1'b0, 1'b0, 64'h0);
        cyc();

        // Asynchronous reset while a transaction is in flight.
        set_req(0, 1'b1, 64'h8000_0200, 3'b010, 8'h00, 64'h0);
        cyc();
        chk("t5_pre_valid", {159'd0, dreq.valid}, {159'd0, 1'b1});
        set_resp(1'b1, 1'b0, 64'h77);
        rst = 1'b0;
        #1;
        chk("t5_rst_valid", {159'd0, dreq.valid}, 160'd0);
        chk("t5_rst_busy", {159'd0, busy}, 160'd0);
        chk("t5_rst_mresp0", rs(mresp[0]), 160'd0);
        apply_reset();
        set_req(0, 1'b1, 64'h8000_0300, 3'b011, 8'h00, 64'h0);
        set_req(1, 1'b1, 64'h8000_0400, 3'b011, 8'h00, 64'h0);
        cyc();
        chk("t5_post_owner", {159'd0, owner}, 160'd0);
        set_resp(1'b0, 1'b1, 64'h1);
        cyc();
        set_req(0, 1'b0, 64'h0, 3'b000, 8'h00, 64'h0);
        set_req(1, 1'b0, 64'h0, 3'b000, 8'h00, 64'h0);
        set_resp(1'b0, 1'b0, 64'h0);
        cyc();

        // Contention right after reset: master 0 first, then master 1.
        apply_reset();
        grant_q.delete();
        auto_en = 1'b1;
        gap_en  = 1'b0;
        remaining[0] = 1;
        remaining[1] = 1;
        drain(80);
        g = (grant_q.size() > 0) ? grant_q[0] : -1;
        chk("t2_first", {128'd0, 32'(g)}, 160'd0);
        g = (grant_q.size() > 1) ? grant_q[1] : -1;
        chk("t2_second", {128'd0, 32'(g)}, {128'd0, 32'd1});
        chk("t2_owner", {159'd0, owner}, {159'd0, 1'b1});

        // Fairness: both masters request back to back.
        apply_reset();
        grant_q.delete();
        remaining[0] = 4;
        remaining[1] = 4;
        c = 0;
        while (grant_q.size() < 4 && c < 120) begin
            cyc();
            c++;
        end
        chk("t3_grant_budget", {159'd0, grant_q.size() >= 4}, {159'd0, 1'b1});
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(RR ? 1'(k % 2) : 1'b0);
        for (int k = 0; k < 4; k++) begin
            g = (k < grant_q.size()) ? grant_q[k] : -1;
            chk($sformatf("t3_grant%0d", k), {128'd0, 32'(g)}, {159'd0, exp_q[k]});
        end
        drain(300);

        // Randomized traffic with idle gaps and junk responses while IDLE.
        gap_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++)
                if (remaining[i] == 0 && $urandom_range(0, 9) == 0) remaining[i] = $urandom_range(1, 3);
            cyc();
        end
        for (int i = 0; i < N; i++) remaining[i] = 0;
        drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
